// File: rtl/accel_frame_gen.sv
// accel_frame_gen: burst generator of test samples sent as UART byte frames.
// Define ACCEL_FRAME_GEN_PARITY_EN to add an even-parity bit to every frame.
module accel_frame_gen #(
  parameter int DATA_W   = 14,
  parameter int BAUD_DIV = 4,
  parameter int GAP_CYC  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [7:0]        num_samples,
  input  logic [15:0]       seed,
  output logic              TX_A,
  output logic              busy,
  output logic              smpl_vld,
  output logic [DATA_W-1:0] smpl_data,
  output logic              done
);
  localparam int NB = (DATA_W + 7) / 8;
  localparam int FW = NB * 8;
  localparam logic [DATA_W-1:0] MSB = DATA_W'(1) << (DATA_W - 1);
`ifdef ACCEL_FRAME_GEN_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, START_BIT, DATA_BITS, STOP_BIT, GAP} state_t;

  state_t              state_q, state_d;
  logic [31:0]         baud_q, baud_d, gap_q, gap_d;
  logic [3:0]          bit_q, bit_d;
  logic [1:0]          byte_q, byte_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                stop_q, stop_d, vld_q, vld_d, done_q, done_d;
  logic [15:0]         lfsr_q, lfsr_d, lfsr_nx;
  logic [2:0]          corner_q, corner_d;
  logic [DATA_W-1:0]   ramp_q, ramp_d, data_q, data_d, corner_val, sample;
  logic [7:0]          cur_byte;
  logic                tx_bit, bit_end, last_smp, smp_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      gap_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      lfsr_q   <= 16'hACE1;
      corner_q <= '0;
      ramp_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      gap_q    <= gap_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      lfsr_q   <= lfsr_d;
      corner_q <= corner_d;
      ramp_q   <= ramp_d;
      data_q   <= data_d;
    end
  end

  assign lfsr_nx    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign corner_val = corner_q == 3'd0 ? ~MSB :
                      corner_q == 3'd1 ? MSB :
                      corner_q == 3'd2 ? '1 :
                      corner_q == 3'd3 ? DATA_W'(1) : '0;
  assign sample     = mode == 2'b01 ? DATA_W'(lfsr_nx) :
                      mode == 2'b10 ? corner_val :
                      mode == 2'b11 ? ramp_q : '0;
  assign cur_byte   = 8'(FW'(data_q) >> {byte_q, 3'b000});
  assign bit_end    = baud_q == 32'(BAUD_DIV - 1);
  // stop arriving on the very edge that closes a sample still ends the burst
  assign last_smp   = stop_q | stop | (num_samples != 8'd0 && cnt_q == num_samples);

  always_comb begin
    tx_bit = cur_byte[bit_q[2:0]];
`ifdef ACCEL_FRAME_GEN_PARITY_EN
    if (bit_q[3]) tx_bit = ^cur_byte;
`endif
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = '0;
    gap_d    = gap_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q | (stop & (state_q != IDLE));
    vld_d    = 1'b0;
    done_d   = 1'b0;
    lfsr_d   = lfsr_q;
    corner_d = corner_q;
    ramp_d   = ramp_q;
    data_d   = data_q;
    smp_end  = 1'b0;
    if (state_q == START_BIT || state_q == DATA_BITS || state_q == STOP_BIT)
      baud_d = bit_end ? '0 : baud_q + 32'd1;
    case (state_q)
      IDLE: if (start) begin
        state_d  = LOAD;
        cnt_d    = '0;
        stop_d   = 1'b0;
        corner_d = '0;
        ramp_d   = '0;
        lfsr_d   = seed == 16'h0000 ? 16'hACE1 : seed;
      end
      LOAD: begin
        state_d  = START_BIT;
        data_d   = sample;
        vld_d    = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        byte_d   = '0;
        bit_d    = '0;
        lfsr_d   = mode == 2'b01 ? lfsr_nx : lfsr_q;
        corner_d = mode == 2'b10 ? (corner_q == 3'd4 ? 3'd0 : corner_q + 3'd1) : corner_q;
        ramp_d   = mode == 2'b11 ? ramp_q + DATA_W'(1) : ramp_q;
      end
      START_BIT: if (bit_end) state_d = DATA_BITS;
      DATA_BITS: if (bit_end) begin
        bit_d = bit_q + 4'd1;
        if (bit_q == LAST_BIT) state_d = STOP_BIT;
      end
      STOP_BIT: if (bit_end) begin
        if (byte_q == 2'(NB - 1)) begin
          gap_d = '0;
          if (GAP_CYC == 0) smp_end = 1'b1;
          else state_d = GAP;
        end else begin
          byte_d  = byte_q + 2'd1;
          bit_d   = '0;
          state_d = START_BIT;
        end
      end
      GAP: begin
        gap_d = gap_q + 32'd1;
        if (gap_q == 32'(GAP_CYC - 1)) smp_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (smp_end) begin
      state_d = last_smp ? IDLE : LOAD;
      done_d  = last_smp;
      if (last_smp) stop_d = 1'b0;
    end
  end

  assign TX_A      = state_q == START_BIT ? 1'b0 : state_q == DATA_BITS ? tx_bit : 1'b1;
  assign busy      = state_q != IDLE;
  assign smpl_vld  = vld_q;
  assign smpl_data = data_q;
  assign done      = done_q;
endmodule
